// File: rtl/hard_png_if.sv
// PNG byte-stream input and decoded image/pixel output bundle.
// No latency of its own; carries the byte handshake and pixel strobe.
// Backpressure: iready from the slave gates acceptance of ibyte.
interface hard_png_if;
    logic        istart;
    logic        ivalid;
    logic [7:0]  ibyte;
    logic        iready;
    logic        ostart;
    logic [2:0]  colortype;
    logic [13:0] width;
    logic [31:0] height;
    logic        ovalid;
    logic [7:0]  opixelr;
    logic [7:0]  opixelg;
    logic [7:0]  opixelb;
    logic [7:0]  opixela;

    modport master (
        output istart, ivalid, ibyte,
        input  iready, ostart, colortype, width, height,
        input  ovalid, opixelr, opixelg, opixelb, opixela
    );

    modport slave (
        input  istart, ivalid, ibyte,
        output iready, ostart, colortype, width, height,
        output ovalid, opixelr, opixelg, opixelb, opixela
    );
endinterface

// File: rtl/hard_png.sv
// PNG decoder for 8-bit non-interlaced images carried in stored zlib blocks.
// Latency: ostart/ovalid one cycle after the last IHDR byte / last pixel byte.
// Backpressure: none; iready is held high out of reset, every byte is consumed.
module hard_png (
    input  logic      clk,
    input  logic      rst,
    hard_png_if.slave bus
);
    typedef enum logic [2:0] {P_IDLE, P_SIG, P_LEN, P_TYPE, P_DATA, P_CRC} pstate_t;
    typedef enum logic [2:0] {Z_HDR, Z_BHDR, Z_LEN, Z_NLEN, Z_RAW, Z_ADLER, Z_DONE} zstate_t;

    localparam logic [31:0] T_IHDR = 32'h49484452;
    localparam logic [31:0] T_PLTE = 32'h504C5445;
    localparam logic [31:0] T_IDAT = 32'h49444154;
    localparam logic [31:0] T_IEND = 32'h49454E44;

    pstate_t st, st_eff, st_nxt;
    zstate_t zst, zst_nxt;
    logic [31:0] cnt, cnt_eff, cnt_nxt, len, ctype;
    logic [15:0] zcnt, zcnt_nxt, blen;
    logic        bfinal;
    logic [13:0] w_sh;
    logic [31:0] h_sh;
    logic [7:0]  pt_sh;
    logic [8:0]  pidx;
    logic [1:0]  pcomp;
    logic [7:0]  pal_r [256];
    logic [7:0]  pal_g [256];
    logic [7:0]  pal_b [256];
    logic        row_filt;
    logic [7:0]  filt;
    logic [15:0] bcnt;
    logic [1:0]  chan;
    logic [31:0] rowcnt;
    logic [3:0][7:0] hist, px, cur;
    logic        rdy_q, ostart_q, ovalid_q;
    logic [2:0]  ct_q;
    logic [13:0] width_q;
    logic [31:0] height_q;
    logic [7:0]  pr, pg, pb, pa, nr, ng, nb, na;
    logic        acc, dbyte, last_data, zacc, raw, emit;
    logic [2:0]  bpp;
    logic [15:0] rowbytes;
    logic [7:0]  sub_add, recon;

    function automatic logic [2:0] map_ct(input logic [7:0] p);
        case (p)
            8'd4:    return 3'd1;
            8'd2:    return 3'd2;
            8'd6:    return 3'd3;
            8'd3:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    assign acc       = bus.ivalid && rdy_q;
    assign dbyte     = acc && (st_eff == P_DATA);
    assign last_data = (cnt_eff == len - 32'd1);
    assign zacc      = dbyte && (ctype == T_IDAT);
    assign raw       = zacc && (zst == Z_RAW);

    // Chunk-level parser next state; istart behaves as if already in SIG at count 0.
    always_comb begin
        st_eff  = bus.istart ? P_SIG : st;
        cnt_eff = bus.istart ? 32'd0 : cnt;
        st_nxt  = st_eff;
        cnt_nxt = cnt_eff;
        if (acc) begin
            case (st_eff)
                P_SIG:  if (cnt_eff == 32'd7) begin st_nxt = P_LEN; cnt_nxt = '0; end
                        else cnt_nxt = cnt_eff + 32'd1;
                P_LEN:  if (cnt_eff == 32'd3) begin st_nxt = P_TYPE; cnt_nxt = '0; end
                        else cnt_nxt = cnt_eff + 32'd1;
                P_TYPE: if (cnt_eff == 32'd3) begin
                            st_nxt  = (len == 32'd0) ? P_CRC : P_DATA;
                            cnt_nxt = '0;
                        end else cnt_nxt = cnt_eff + 32'd1;
                P_DATA: if (last_data) begin st_nxt = P_CRC; cnt_nxt = '0; end
                        else cnt_nxt = cnt_eff + 32'd1;
                P_CRC:  if (cnt_eff == 32'd3) begin
                            st_nxt  = (ctype == T_IEND) ? P_IDLE : P_LEN;
                            cnt_nxt = '0;
                        end else cnt_nxt = cnt_eff + 32'd1;
                default: ;
            endcase
        end
    end

    // zlib/deflate stored-block walker, advanced only by IDAT payload bytes.
    always_comb begin
        zst_nxt  = zst;
        zcnt_nxt = zcnt;
        if (zacc) begin
            case (zst)
                Z_HDR:   if (zcnt == 16'd1) begin zst_nxt = Z_BHDR; zcnt_nxt = '0; end
                         else zcnt_nxt = zcnt + 16'd1;
                Z_BHDR:  begin zst_nxt = Z_LEN; zcnt_nxt = '0; end
                Z_LEN:   if (zcnt == 16'd1) begin zst_nxt = Z_NLEN; zcnt_nxt = '0; end
                         else zcnt_nxt = zcnt + 16'd1;
                Z_NLEN:  if (zcnt == 16'd1) begin
                             zcnt_nxt = '0;
                             if (blen == 16'd0) zst_nxt = bfinal ? Z_ADLER : Z_BHDR;
                             else               zst_nxt = Z_RAW;
                         end else zcnt_nxt = zcnt + 16'd1;
                Z_RAW:   if (zcnt == blen - 16'd1) begin
                             zst_nxt  = bfinal ? Z_ADLER : Z_BHDR;
                             zcnt_nxt = '0;
                         end else zcnt_nxt = zcnt + 16'd1;
                Z_ADLER: if (zcnt == 16'd3) begin zst_nxt = Z_DONE; zcnt_nxt = '0; end
                         else zcnt_nxt = zcnt + 16'd1;
                default: ;
            endcase
        end
    end

    // Row geometry, Sub-filter reconstruction and pixel channel formatting.
    always_comb begin
        case (ct_q)
            3'd1:    bpp = 3'd2;
            3'd2:    bpp = 3'd3;
            3'd3:    bpp = 3'd4;
            default: bpp = 3'd1;
        endcase
        rowbytes = {2'b00, width_q} * {13'b0, bpp};
        sub_add  = (filt == 8'd1 && bcnt >= {13'b0, bpp}) ? hist[bpp[1:0] - 2'd1] : 8'd0;
        recon    = bus.ibyte + sub_add;
        cur      = px;
        cur[chan] = recon;
        emit     = raw && !row_filt && (chan == bpp[1:0] - 2'd1) && (rowcnt < height_q);
        nr = cur[0]; ng = cur[0]; nb = cur[0]; na = 8'hFF;
        case (ct_q)
            3'd1: na = cur[1];
            3'd2: begin ng = cur[1]; nb = cur[2]; end
            3'd3: begin ng = cur[1]; nb = cur[2]; na = cur[3]; end
            3'd4: begin nr = pal_r[cur[0]]; ng = pal_g[cur[0]]; nb = pal_b[cur[0]]; end
            default: ;
        endcase
    end

    // Parser and zlib state registers; istart restarts the zlib walker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= P_IDLE; cnt <= '0; zst <= Z_HDR; zcnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            zst  <= bus.istart ? Z_HDR : zst_nxt;
            zcnt <= bus.istart ? 16'd0 : zcnt_nxt;
        end
    end

    // Palette storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (dbyte && ctype == T_PLTE && !pidx[8]) begin
            case (pcomp)
                2'd0:    pal_r[pidx[7:0]] <= bus.ibyte;
                2'd1:    pal_g[pidx[7:0]] <= bus.ibyte;
                default: pal_b[pidx[7:0]] <= bus.ibyte;
            endcase
        end
    end

    // Chunk header capture, IHDR decode, block header capture and row/pixel datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len <= '0; ctype <= '0; w_sh <= '0; h_sh <= '0; pt_sh <= '0;
            pidx <= '0; pcomp <= '0; bfinal <= 1'b0; blen <= '0;
            row_filt <= 1'b1; filt <= '0; bcnt <= '0; chan <= '0; rowcnt <= '0;
            hist <= '0; px <= '0;
            rdy_q <= 1'b0; ostart_q <= 1'b0; ovalid_q <= 1'b0;
            ct_q <= '0; width_q <= '0; height_q <= '0;
            pr <= '0; pg <= '0; pb <= '0; pa <= '0;
        end else begin
            rdy_q    <= 1'b1;
            ostart_q <= 1'b0;
            ovalid_q <= 1'b0;
            if (acc && st_eff == P_LEN)  len   <= {len[23:0], bus.ibyte};
            if (acc && st_eff == P_TYPE) ctype <= {ctype[23:0], bus.ibyte};
            if (acc && st_eff == P_TYPE && cnt_eff == 32'd3) begin
                pidx <= '0; pcomp <= '0;
            end
            if (dbyte && ctype == T_IHDR) begin
                case (cnt_eff)
                    32'd0, 32'd1, 32'd2, 32'd3: w_sh <= {w_sh[5:0], bus.ibyte};
                    32'd4, 32'd5, 32'd6, 32'd7: h_sh <= {h_sh[23:0], bus.ibyte};
                    32'd9:                      pt_sh <= bus.ibyte;
                    default: ;
                endcase
                if (last_data) begin
                    ostart_q <= 1'b1;
                    width_q  <= w_sh;
                    height_q <= h_sh;
                    ct_q     <= map_ct(pt_sh);
                end
            end
            if (dbyte && ctype == T_PLTE) begin
                if (pcomp == 2'd2) begin pcomp <= '0; pidx <= pidx + 9'd1; end
                else pcomp <= pcomp + 2'd1;
            end
            if (bus.istart) begin
                bfinal <= 1'b0; blen <= '0; row_filt <= 1'b1; filt <= '0;
                bcnt <= '0; chan <= '0; rowcnt <= '0; hist <= '0;
            end else if (zacc) begin
                if (zst == Z_BHDR) bfinal <= bus.ibyte[0];
                if (zst == Z_LEN && zcnt == 16'd0) blen[7:0]  <= bus.ibyte;
                if (zst == Z_LEN && zcnt == 16'd1) blen[15:8] <= bus.ibyte;
                if (raw && row_filt) begin
                    filt     <= bus.ibyte;
                    row_filt <= (rowbytes == 16'd0);
                    bcnt     <= '0;
                    chan     <= '0;
                end else if (raw) begin
                    hist       <= {hist[2:0], recon};
                    px[chan]   <= recon;
                    chan       <= (chan == bpp[1:0] - 2'd1) ? 2'd0 : chan + 2'd1;
                    if (emit) begin
                        ovalid_q <= 1'b1;
                        pr <= nr; pg <= ng; pb <= nb; pa <= na;
                    end
                    if (bcnt == rowbytes - 16'd1) begin
                        row_filt <= 1'b1;
                        rowcnt   <= rowcnt + 32'd1;
                    end else begin
                        bcnt <= bcnt + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.iready    = rdy_q;
    assign bus.ostart    = ostart_q;
    assign bus.colortype = ct_q;
    assign bus.width     = width_q;
    assign bus.height    = height_q;
    assign bus.ovalid    = ovalid_q;
    assign bus.opixelr   = pr;
    assign bus.opixelg   = pg;
    assign bus.opixelb   = pb;
    assign bus.opixela   = pa;
endmodule

// File: tb/tb_hard_png.sv
// Directed bench for hard_png: hand-built PNG streams, pixels checked against constants.
// Pixel/ostart pulses are collected on the falling edge and compared after each stream.
// Inputs change 1 time unit after the rising edge.
module tb_hard_png;
    localparam logic [31:0] T_IHDR = 32'h49484452;
    localparam logic [31:0] T_PLTE = 32'h504C5445;
    localparam logic [31:0] T_IDAT = 32'h49444154;
    localparam logic [31:0] T_IEND = 32'h49454E44;
    localparam logic [31:0] T_TEXT = 32'h74455874;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hard_png_if bus();

    hard_png u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ostart = 0;
    logic [31:0] pix_q[$];
    logic [7:0]  stream[$];
    logic [7:0]  cdata[$];

    // Collect output pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.ostart) n_ostart++;
        if (bus.ovalid) pix_q.push_back({bus.opixelr, bus.opixelg, bus.opixelb, bus.opixela});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic addn(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) cdata.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic add_sig();
        logic [63:0] s;
        s = 64'h89504E470D0A1A0A;
        for (int i = 7; i >= 0; i--) stream.push_back(s[8*i +: 8]);
    endtask

    task automatic add_chunk(input logic [31:0] t);
        logic [31:0] l;
        logic [31:0] crc;
        l = cdata.size();
        crc = 32'hDEADBEEF;
        for (int i = 3; i >= 0; i--) stream.push_back(l[8*i +: 8]);
        for (int i = 3; i >= 0; i--) stream.push_back(t[8*i +: 8]);
        foreach (cdata[i]) stream.push_back(cdata[i]);
        for (int i = 3; i >= 0; i--) stream.push_back(crc[8*i +: 8]);
        cdata.delete();
    endtask

    task automatic add_ihdr(input logic [31:0] w, input logic [31:0] h, input logic [7:0] pt);
        addn({w, h, 8'd8, pt, 24'd0}, 13);
        add_chunk(T_IHDR);
    endtask

    task automatic build_gray1();
        add_sig();
        add_ihdr(1, 1, 8'd0);
        addn(72'h78_01_01_0200_FDFF_00_80, 9);
        addn(32'h01020304, 4);
        add_chunk(T_IDAT);
        add_chunk(T_IEND);
    endtask

    // Send the first n bytes of the built stream; istart optionally rides on byte 0.
    task automatic run_stream(input int n, input bit strt);
        for (int i = 0; i < n; i++) begin
            bus.istart = strt && (i == 0);
            bus.ivalid = 1'b1;
            bus.ibyte  = stream[i];
            @(posedge clk); #1;
        end
        bus.istart = 1'b0;
        bus.ivalid = 1'b0;
        bus.ibyte  = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        stream.delete();
    endtask

    task automatic clear_obs();
        n_ostart = 0;
        pix_q.delete();
    endtask

    function automatic logic [31:0] pix(input int i);
        return (pix_q.size() > i) ? pix_q[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        bus.istart = 1'b0;
        bus.ivalid = 1'b0;
        bus.ibyte  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_iready", 64'(bus.iready), 64'd0);
        chk("rst_ostart", 64'(bus.ostart), 64'd0);
        chk("rst_ovalid", 64'(bus.ovalid), 64'd0);
        chk("rst_width",  64'(bus.width),  64'd0);
        chk("rst_height", 64'(bus.height), 64'd0);
        chk("rst_pixel",  64'({bus.opixelr, bus.opixelg, bus.opixelb, bus.opixela, bus.colortype}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("iready_up", 64'(bus.iready), 64'd1);

        // A full image without istart is ignored
        clear_obs();
        build_gray1();
        run_stream(stream.size(), 1'b0);
        chk("nostart_ostart", 64'(n_ostart), 64'd0);
        chk("nostart_pix", 64'(pix_q.size()), 64'd0);

        // IHDR 3x2 RGBA
        clear_obs();
        add_sig();
        add_ihdr(3, 2, 8'd6);
        add_chunk(T_IEND);
        run_stream(stream.size(), 1'b1);
        chk("ihdr_ostart", 64'(n_ostart), 64'd1);
        chk("ihdr_ct", 64'(bus.colortype), 64'd3);
        chk("ihdr_w", 64'(bus.width), 64'd3);
        chk("ihdr_h", 64'(bus.height), 64'd2);

        // 1x1 gray, pixel 80
        clear_obs();
        build_gray1();
        run_stream(stream.size(), 1'b1);
        chk("gray_ostart", 64'(n_ostart), 64'd1);
        chk("gray_ct", 64'(bus.colortype), 64'd0);
        chk("gray_npix", 64'(pix_q.size()), 64'd1);
        chk("gray_pix", 64'(pix(0)), 64'h808080FF);

        // 2x1 RGB with Sub filter
        clear_obs();
        add_sig();
        add_ihdr(2, 1, 8'd2);
        addn(56'h78_01_01_0700_F8FF, 7);
        addn(56'h01_102030_010101, 7);
        addn(32'h0, 4);
        add_chunk(T_IDAT);
        add_chunk(T_IEND);
        run_stream(stream.size(), 1'b1);
        chk("rgb_npix", 64'(pix_q.size()), 64'd2);
        chk("rgb_pix0", 64'(pix(0)), 64'h102030FF);
        chk("rgb_pix1", 64'(pix(1)), 64'h112131FF);

        // Palette image, index 1
        clear_obs();
        add_sig();
        add_ihdr(1, 1, 8'd3);
        addn(48'h000000_AABBCC, 6);
        add_chunk(T_PLTE);
        addn(72'h78_01_01_0200_FDFF_00_01, 9);
        addn(32'h0, 4);
        add_chunk(T_IDAT);
        add_chunk(T_IEND);
        run_stream(stream.size(), 1'b1);
        chk("pal_ct", 64'(bus.colortype), 64'd4);
        chk("pal_npix", 64'(pix_q.size()), 64'd1);
        chk("pal_pix", 64'(pix(0)), 64'hAABBCCFF);

        // Stored block split over two IDATs with an unknown chunk between
        clear_obs();
        add_sig();
        add_ihdr(2, 1, 8'd2);
        addn(80'h78_01_01_0700_F8FF_011020, 10);
        add_chunk(T_IDAT);
        addn(24'h616263, 3);
        add_chunk(T_TEXT);
        addn(32'h30_010101, 4);
        addn(32'h0, 4);
        add_chunk(T_IDAT);
        add_chunk(T_IEND);
        run_stream(stream.size(), 1'b1);
        chk("split_npix", 64'(pix_q.size()), 64'd2);
        chk("split_pix0", 64'(pix(0)), 64'h102030FF);
        chk("split_pix1", 64'(pix(1)), 64'h112131FF);

        // Extra row beyond height is suppressed; filter 2 acts as None
        clear_obs();
        add_sig();
        add_ihdr(1, 1, 8'd0);
        addn(56'h78_01_01_0400_FBFF, 7);
        addn(32'h02_80_00_55, 4);
        addn(32'h0, 4);
        add_chunk(T_IDAT);
        add_chunk(T_IEND);
        run_stream(stream.size(), 1'b1);
        chk("hlim_npix", 64'(pix_q.size()), 64'd1);
        chk("hlim_pix", 64'(pix(0)), 64'h808080FF);

        // Reset in the middle of IDAT, then a clean image
        clear_obs();
        build_gray1();
        run_stream(49, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_iready", 64'(bus.iready), 64'd0);
        chk("midrst_wh", 64'({bus.width, bus.height}), 64'd0);
        chk("midrst_ovalid", 64'(bus.ovalid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        clear_obs();
        build_gray1();
        run_stream(stream.size(), 1'b1);
        chk("postrst_ostart", 64'(n_ostart), 64'd1);
        chk("postrst_w", 64'(bus.width), 64'd1);
        chk("postrst_npix", 64'(pix_q.size()), 64'd1);
        chk("postrst_pix", 64'(pix(0)), 64'h808080FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hard_png.md
HARD_PNG -- requirements
Module: hard_png

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 istart  input  1  one-cycle pulse that begins a new PNG stream and aborts any stream in progress.
REQ-004 ivalid  input  1  ibyte is valid this cycle.
REQ-005 ibyte  input  8  PNG file byte stream, in file order.
REQ-006 iready  output  1  byte accepted when ivalid&&iready.
REQ-007 ostart  output  1  one-cycle pulse when image configuration is valid.
REQ-008 colortype  output  3  0 gray, 1 gray+A, 2 RGB, 3 RGBA, 4 RGB-palette.
REQ-009 width  output  14  image width in pixels.
REQ-010 height  output  32  image height in rows.
REQ-011 ovalid  output  1  one-cycle pixel strobe.
REQ-012 opixelr/opixelg/opixelb/opixela  output  8 each  pixel channels.

Function
REQ-013 iready SHALL be 1 in every cycle out of reset; bytes accepted before the first istart SHALL be ignored.
REQ-014 Parser states SHALL be: IDLE, SIG (8 bytes, consumed unchecked), LEN (4 bytes, big-endian), TYPE (4 bytes), DATA (LEN bytes), CRC (4 bytes, ignored), then back to LEN; after the CRC of IEND the parser SHALL enter IDLE.
REQ-015 istart SHALL force state SIG, clear the zlib/filter state and the byte counters; if istart and a valid byte coincide, that byte SHALL be the first signature byte.
REQ-016 IHDR data SHALL be decoded as: width = low 14 bits of bytes 0-3; height = bytes 4-7; bit depth = byte 8; PNG colour type = byte 9; bytes 10-12 ignored.
REQ-017 Colortype mapping: PNG 0->0, 4->1, 2->2, 6->3, 3->4; only bit depth 8 and non-interlaced images are supported; other values produce undefined pixels but the parser SHALL still track chunk boundaries.
REQ-018 ostart SHALL pulse the cycle after the last IHDR data byte is accepted; colortype/width/height SHALL update at that edge and hold until the next IHDR.
REQ-019 PLTE data SHALL be stored as up to 256 RGB triplets (index = byte offset / 3).
REQ-020 Chunk types other than IHDR, PLTE, IDAT and IEND SHALL have their data skipped.
REQ-021 IDAT data of all IDAT chunks SHALL form one continuous zlib stream: 2 header bytes skipped; then deflate blocks.
REQ-022 Only stored blocks SHALL be supported: 1 header byte (bit0 BFINAL, bits2:1 BTYPE=00), LEN (2 bytes, little-endian), NLEN (2 bytes, ignored), then LEN raw bytes; after the raw bytes a new block header follows unless BFINAL was set, in which case 4 Adler-32 bytes are skipped.
REQ-023 The raw byte stream SHALL be split into rows of 1 filter byte + width*bpp bytes, where bpp = 1, 2, 3, 4, 1 for colortype 0, 1, 2, 3, 4.
REQ-024 Filter 0 (None) SHALL pass bytes unchanged; filter 1 (Sub) SHALL add the reconstructed byte bpp positions earlier in the same row, modulo 256, with 0 used for the first pixel; filters 2-4 SHALL be treated as None.
REQ-025 ovalid SHALL pulse the cycle after the last byte of a pixel is accepted.
REQ-026 Pixel channels: gray gives r=g=b=Y, a=FF; gray+A gives r=g=b=Y, a=A; RGB gives a=FF; RGBA is taken directly; palette gives PLTE[index], a=FF.
REQ-027 Row and pixel counters SHALL wrap at row end; no pixels SHALL be emitted after height rows.

Reset
REQ-028 On rst, all outputs SHALL be 0, including iready, and the state SHALL be IDLE.
REQ-029 When rst is asserted mid-stream, the design SHALL discard the partial image, and the PLTE contents become don't-care.

Verification
REQ-030 IHDR width 3, height 2, PNG type 6 -> ostart pulse once; colortype=3, width=3, height=2.
REQ-031 1x1 gray image, filter 0, pixel byte 80 -> exactly one ovalid with r=g=b=80, a=FF.
REQ-032 2x1 RGB image, row 01 10 20 30 01 01 01 -> pixels (10,20,30,FF) then (11,21,31,FF).
REQ-033 Palette image with PLTE entry 1 = (AA,BB,CC) and pixel index 01 -> r=AA, g=BB, b=CC, a=FF.
REQ-034 Stored block split across two IDAT chunks, plus an unknown chunk between them -> pixels identical to the single-chunk case.
REQ-035 rst mid-IDAT, then istart and a full 1x1 gray image (pixel 80) -> a correct ostart and exactly one pixel; no stale pixels.
